mmio_uart_tx: RTL and testbench

// - Memory-mapped UART transmitter on the CPU data-store path.
// - Consumes the CPU write strobe (wr_valid/wr_addr/wr_data), queues bytes in a FIFO and serializes them 8N1, LSB first.
// - Exposes a status word on the CPU read path.
// - First peripheral behind the core; all other addresses are ignored.

---
 rtl/mmio_uart_tx_pkg.sv | 28 ++
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/mmio_uart_tx_fifo.sv | 56 +++++
 rtl/mmio_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package mmio_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [31:0] OFS_TXDATA = 32'h0;
    localparam logic [31:0] OFS_STATUS = 32'h4;
    localparam logic [31:0] OFS_CTRL   = 32'h8;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_ACTIVE  = 2;
    localparam int STAT_CNT_LSB = 4;

    function automatic logic [3:0] sat_nibble(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU store/load bus as seen by the UART transmitter.
interface mmio_uart_tx_if;
    logic        i_wr_valid;
    logic [31:0] i_wr_addr;
    logic [31:0] i_wr_data;
    logic [31:0] i_rd_addr;
    logic [31:0] o_rd_data;

    modport master (output i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr, input o_rd_data);
    modport slave  (input i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr, output o_rd_data);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop happens on the same edge.
module mmio_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, sticky overflow, serializer FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
//   state  | meaning
//   IDLE   | line high, waiting for a queued byte
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | even parity of the byte (UART_TX_PARITY_EN only)
//   STOP   | stop bit (high); may chain directly into the next START
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          i_reset,
    mmio_uart_tx_if.slave bus,
    output logic          o_tx,
    output logic          o_busy,
    output logic          o_overflow
);
    localparam int                CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int                CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push_req;
    logic             clr_req;
    logic             fifo_pop;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [31:0]      status;
    logic             unused_wr_data;
`ifdef UART_TX_PARITY_EN
    logic             par_bit;
`endif

    assign push_req = bus.i_wr_valid && (bus.i_wr_addr == BASE_ADDR + OFS_TXDATA);
    assign clr_req  = bus.i_wr_valid && (bus.i_wr_addr == BASE_ADDR + OFS_CTRL) && bus.i_wr_data[0];
    assign unused_wr_data = &{1'b0, bus.i_wr_data[31:8]};

    // Pops only from registered empty, so a byte pushed into an empty FIFO is never bypassed.
    assign fifo_pop = !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && (cnt == '0)));

    mmio_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .i_reset   (i_reset),
        .push      (push_req),
        .push_data (bus.i_wr_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            o_overflow <= 1'b1;
        end else if (clr_req) begin
            o_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            o_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_STOP: begin
                    if (state == ST_STOP && cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (fifo_pop) begin
                        state <= ST_START;
                        cnt   <= BAUD_RELOAD;
                        shreg <= fifo_rd_data;
                        o_tx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^fifo_rd_data;
`endif
                    end else begin
                        state <= ST_IDLE;
                        o_tx  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == '0) begin
                        state   <= ST_DATA;
                        cnt     <= BAUD_RELOAD;
                        bit_idx <= '0;
                        o_tx    <= shreg[0];
                        shreg   <= shreg >> 1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            o_tx  <= par_bit;
`else
                            state <= ST_STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == '0) begin
                        state <= ST_STOP;
                        cnt   <= BAUD_RELOAD;
                        o_tx  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        status                           = '0;
        status[STAT_FULL]                = fifo_full;
        status[STAT_EMPTY]               = fifo_empty;
        status[STAT_ACTIVE]              = (state != ST_IDLE);
        status[STAT_CNT_LSB +: 4]        = sat_nibble(32'(fifo_count));
    end

    assign bus.o_rd_data = (bus.i_rd_addr == BASE_ADDR + OFS_STATUS) ? status : '0;
    assign o_busy        = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam int          CPB    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          FB     = 11;
`else
    localparam int          FB     = 10;
`endif

    logic clk = 1'b0;
    logic i_reset;
    logic o_tx;
    logic o_busy;
    logic o_overflow;
    int   n_cmp = 0;
    int   n_err = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .bus        (bus),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = a;
        bus.i_wr_data  = d;
        tick();
        bus.i_wr_valid = 1'b0;
    endtask

    // Entered at frame cycle 'skip' (0 = first cycle of the start bit); samples every remaining cycle.
    task automatic check_frame(input string tag, input logic [7:0] b, input int skip);
        logic [FB-1:0]  bits;
        logic [CPB-1:0] seen;
        logic [CPB-1:0] mask;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        bits[FB-1] = 1'b1;
        for (int k = 0; k < FB; k++) begin
            seen = '0;
            mask = '0;
            for (int c = 0; c < CPB; c++) begin
                if (k * CPB + c >= skip) begin
                    seen[c] = o_tx;
                    mask[c] = 1'b1;
                    tick();
                end
            end
            if (mask != '0)
                chk($sformatf("%s bit%0d", tag, k), 32'(seen & mask), 32'({CPB{bits[k]}} & mask));
        end
    endtask

    initial begin
        i_reset        = 1'b1;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        bus.i_rd_addr  = A_STAT;
        repeat (3) tick();
        i_reset = 1'b0;
        chk("rst tx", 32'(o_tx), 32'd1);
        chk("rst status", bus.o_rd_data, 32'h2);
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst ovf", 32'(o_overflow), 32'd0);

        // single byte
        wr(A_TX, 32'h55);
        chk("single tx before pop", 32'(o_tx), 32'd1);
        chk("single busy", 32'(o_busy), 32'd1);
        chk("single status queued", bus.o_rd_data, 32'h10);
        tick();
        check_frame("single", 8'h55, 0);
        chk("single busy end", 32'(o_busy), 32'd0);
        chk("single status end", bus.o_rd_data, 32'h2);

        // back-to-back
        wr(A_TX, 32'h01);
        wr(A_TX, 32'h02);
        wr(A_TX, 32'h03);
        chk("b2b status", bus.o_rd_data, 32'h24);
        check_frame("b2b f1", 8'h01, 1);
        check_frame("b2b f2", 8'h02, 0);
        check_frame("b2b f3", 8'h03, 0);
        chk("b2b busy end", 32'(o_busy), 32'd0);
        chk("b2b status end", bus.o_rd_data, 32'h2);

        // overflow: 9 accepted (1 in flight + 8 queued), 10th finds FIFO full
        for (int k = 0; k < 9; k++) wr(A_TX, 32'(8'hA0 + k));
        chk("ovf status full", bus.o_rd_data, 32'h85);
        chk("ovf before", 32'(o_overflow), 32'd0);
        wr(A_TX, 32'hA9);
        chk("ovf set", 32'(o_overflow), 32'd1);
        chk("ovf status after drop", bus.o_rd_data, 32'h85);
        wr(A_CTRL, 32'h0);
        chk("ovf kept by ctrl 0", 32'(o_overflow), 32'd1);
        wr(A_CTRL, 32'h1);
        chk("ovf cleared", 32'(o_overflow), 32'd0);
        check_frame("ovf f0", 8'hA0, 10);
        for (int k = 1; k < 9; k++) check_frame($sformatf("ovf f%0d", k), 8'(8'hA0 + k), 0);
        chk("ovf busy end", 32'(o_busy), 32'd0);

        // push while full on the edge where STOP pops
        for (int k = 0; k < 9; k++) wr(A_TX, 32'(8'hB0 + k));
        repeat (FB * CPB - 8) tick();
        chk("fullpop status before", bus.o_rd_data, 32'h85);
        wr(A_TX, 32'hEE);
        chk("fullpop ovf", 32'(o_overflow), 32'd0);
        chk("fullpop status after", bus.o_rd_data, 32'h85);
        for (int k = 1; k < 9; k++) check_frame($sformatf("fullpop f%0d", k), 8'(8'hB0 + k), 0);
        check_frame("fullpop fEE", 8'hEE, 0);
        chk("fullpop busy end", 32'(o_busy), 32'd0);

        // reset during data bit 3, with overflow set and bytes queued
        wr(A_TX, 32'hC3);
        for (int k = 0; k < 9; k++) wr(A_TX, 32'(k));
        chk("midrst ovf before", 32'(o_overflow), 32'd1);
        repeat (9) tick();
        chk("midrst bit3", 32'(o_tx), 32'd0);
        i_reset = 1'b1;
        tick();
        chk("midrst tx", 32'(o_tx), 32'd1);
        chk("midrst status", bus.o_rd_data, 32'h2);
        chk("midrst ovf", 32'(o_overflow), 32'd0);
        chk("midrst busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        repeat (8) tick();
        chk("postrst tx", 32'(o_tx), 32'd1);
        chk("postrst status", bus.o_rd_data, 32'h2);

        // address decode
        wr(BASE + 32'hC, 32'h5A);
        wr(32'h0, 32'h5A);
        wr(A_STAT, 32'h5A);
        wr(A_CTRL, 32'h5A);
        tick();
        chk("decode busy", 32'(o_busy), 32'd0);
        chk("decode tx", 32'(o_tx), 32'd1);
        chk("decode status", bus.o_rd_data, 32'h2);
        bus.i_rd_addr = BASE;
        tick();
        chk("decode rd base+0", bus.o_rd_data, 32'h0);
        bus.i_rd_addr = A_CTRL;
        tick();
        chk("decode rd base+8", bus.o_rd_data, 32'h0);
        bus.i_rd_addr = A_STAT;

        // odd-weight byte exercises the parity bit when enabled
        wr(A_TX, 32'h07);
        tick();
        check_frame("byte07", 8'h07, 0);
        chk("byte07 busy end", 32'(o_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
